// File: rtl/jx2_ic_tile_d.sv
// Two-bank (even/odd 16-byte tile) direct-mapped instruction cache with a
// 32-bit fetch window that may straddle tiles and blocks; fills are 32-byte lines.
module jx2_ic_tile_d #(
    parameter int IC_LINES = 16,
    parameter int PA_BITS  = 20
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        regInPc,
    input  logic               icFlush,
    output logic [31:0]        regOutPcVal,
    output logic [1:0]         regOutPcOK,
    input  logic [255:0]       memPcData,
    input  logic [1:0]         memPcOK,
    output logic [PA_BITS-1:0] memPcAddr,
    output logic               memPcOE
);

    localparam int IDX_W = $clog2(IC_LINES);
    localparam int BLK_W = PA_BITS - 5;
    localparam int TAG_W = BLK_W - IDX_W;

    localparam logic [1:0] ST_READY = 2'b00;
    localparam logic [1:0] ST_OK    = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;
    localparam logic [1:0] ST_FAULT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE, S_FAULT} state_t;

    state_t             state_q, state_d;
    logic               oe_q, oe_d;
    logic [PA_BITS-1:0] addr_q, addr_d;
    logic [BLK_W-1:0]   fault_blk_q, fault_blk_d;
    logic               flush_pend_q, flush_pend_d;
    logic [IC_LINES-1:0] even_vld_q, even_vld_d, odd_vld_q, odd_vld_d;

    logic [127:0]       even_tile_q [IC_LINES];
    logic [127:0]       odd_tile_q  [IC_LINES];
    logic [TAG_W-1:0]   even_tag_q  [IC_LINES];
    logic [TAG_W-1:0]   odd_tag_q   [IC_LINES];

    logic [2:0]         pc_w_s, w_nx_s;
    logic               pc_t_s;
    logic [BLK_W-1:0]   blk_s, blk1_s, miss_blk_s, req_blk_s;
    logic [IDX_W-1:0]   idx_s, idx1_s, req_idx_s;
    logic [TAG_W-1:0]   tag_s, tag1_s, req_tag_s;
    logic [127:0]       tile_a_s, tile_b_s;
    logic               a_ok_s, b_ok_s, hit_s, fault_match_s, fill_we_s;
    logic [15:0]        hw_lo_s, hw_hi_s;
    logic               pc_unused_s;

    assign pc_w_s      = regInPc[3:1];
    assign pc_t_s      = regInPc[4];
    assign blk_s       = regInPc[PA_BITS-1:5];
    assign blk1_s      = blk_s + BLK_W'(1);
    assign idx_s       = blk_s[IDX_W-1:0];
    assign tag_s       = blk_s[BLK_W-1:IDX_W];
    assign idx1_s      = blk1_s[IDX_W-1:0];
    assign tag1_s      = blk1_s[BLK_W-1:IDX_W];
    assign req_blk_s   = addr_q[PA_BITS-1:5];
    assign req_idx_s   = req_blk_s[IDX_W-1:0];
    assign req_tag_s   = req_blk_s[BLK_W-1:IDX_W];
    assign pc_unused_s = ^{regInPc[31:PA_BITS], regInPc[0]};

    // Tile A holds halfword w; tile B supplies the next halfword when w wraps.
    always_comb begin
        if (pc_t_s) begin
            tile_a_s = odd_tile_q[idx_s];
            a_ok_s   = odd_vld_q[idx_s] && (odd_tag_q[idx_s] == tag_s);
            tile_b_s = even_tile_q[idx1_s];
            b_ok_s   = even_vld_q[idx1_s] && (even_tag_q[idx1_s] == tag1_s);
        end else begin
            tile_a_s = even_tile_q[idx_s];
            a_ok_s   = even_vld_q[idx_s] && (even_tag_q[idx_s] == tag_s);
            tile_b_s = odd_tile_q[idx_s];
            b_ok_s   = odd_vld_q[idx_s] && (odd_tag_q[idx_s] == tag_s);
        end
    end

    // Hit detection, missing-block selection and fetch window assembly.
    always_comb begin
        hit_s   = a_ok_s && ((pc_w_s != 3'd7) || b_ok_s);
        w_nx_s  = pc_w_s + 3'd1;
        hw_lo_s = tile_a_s[{pc_w_s, 4'b0000} +: 16];
        if (!a_ok_s) begin
            miss_blk_s = blk_s;
        end else if (pc_t_s) begin
            miss_blk_s = blk1_s;
        end else begin
            miss_blk_s = blk_s;
        end
        if (pc_w_s == 3'd7) begin
            hw_hi_s = tile_b_s[15:0];
        end else begin
            hw_hi_s = tile_a_s[{w_nx_s, 4'b0000} +: 16];
        end
    end

    assign fault_match_s = (state_q == S_FAULT) && !hit_s && (miss_blk_s == fault_blk_q);
    assign regOutPcVal   = {hw_hi_s, hw_lo_s};
    assign regOutPcOK    = fault_match_s ? ST_FAULT : (hit_s ? ST_OK : ST_HOLD);
    assign memPcOE       = oe_q;
    assign memPcAddr     = addr_q;

    // Fill/fault sequencing and valid-bit maintenance.
    always_comb begin
        state_d      = state_q;
        oe_d         = oe_q;
        addr_d       = addr_q;
        fault_blk_d  = fault_blk_q;
        flush_pend_d = flush_pend_q;
        fill_we_s    = 1'b0;
        even_vld_d   = even_vld_q;
        odd_vld_d    = odd_vld_q;
        case (state_q)
            S_IDLE: begin
                flush_pend_d = 1'b0;
                if (!hit_s && !icFlush) begin
                    state_d = S_REQ;
                    oe_d    = 1'b1;
                    addr_d  = {miss_blk_s, 5'b00000};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (icFlush) begin
                    flush_pend_d = 1'b1;
                end else begin
                    flush_pend_d = flush_pend_q;
                end
                if (memPcOK == ST_OK) begin
                    fill_we_s = 1'b1;
                    oe_d      = 1'b0;
                    state_d   = S_RELEASE;
                end else if (memPcOK == ST_FAULT) begin
                    oe_d        = 1'b0;
                    fault_blk_d = req_blk_s;
                    state_d     = S_FAULT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_RELEASE: begin
                if (memPcOK != ST_OK) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_FAULT: begin
                if (!fault_match_s && (memPcOK == ST_READY)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: begin
                state_d = S_IDLE;
                oe_d    = 1'b0;
            end
        endcase
        // A flush seen during the request or at the fill edge leaves the line invalid.
        if (fill_we_s && !flush_pend_q && !icFlush) begin
            even_vld_d[req_idx_s] = 1'b1;
            odd_vld_d[req_idx_s]  = 1'b1;
        end else begin
            even_vld_d = even_vld_d;
        end
        if (icFlush) begin
            even_vld_d = '0;
            odd_vld_d  = '0;
        end else begin
            odd_vld_d = odd_vld_d;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            oe_q         <= 1'b0;
            addr_q       <= '0;
            fault_blk_q  <= '0;
            flush_pend_q <= 1'b0;
            even_vld_q   <= '0;
            odd_vld_q    <= '0;
        end else begin
            state_q      <= state_d;
            oe_q         <= oe_d;
            addr_q       <= addr_d;
            fault_blk_q  <= fault_blk_d;
            flush_pend_q <= flush_pend_d;
            even_vld_q   <= even_vld_d;
            odd_vld_q    <= odd_vld_d;
        end
    end

    // Tile and tag storage; a fill overwrites both banks at the requested index.
    always_ff @(posedge clock) begin
        if (fill_we_s && !reset) begin
            even_tile_q[req_idx_s] <= memPcData[127:0];
            odd_tile_q[req_idx_s]  <= memPcData[255:128];
            even_tag_q[req_idx_s]  <= req_tag_s;
            odd_tag_q[req_idx_s]   <= req_tag_s;
        end
    end

endmodule

// File: tb/tb_jx2_ic_tile_d.sv
// Scoreboard bench for jx2_ic_tile_d: stimulus queues expected status and
// request addresses; a monitor pops and compares them.
module tb_jx2_ic_tile_d;

    localparam logic [1:0] R_READY = 2'b00;
    localparam logic [1:0] R_OK    = 2'b01;
    localparam logic [1:0] R_HOLD  = 2'b10;
    localparam logic [1:0] R_FAULT = 2'b11;

    logic         clock = 1'b0;
    logic         reset;
    logic [31:0]  regInPc;
    logic         icFlush;
    logic [31:0]  regOutPcVal;
    logic [1:0]   regOutPcOK;
    logic [255:0] memPcData;
    logic [1:0]   memPcOK;
    logic [19:0]  memPcAddr;
    logic         memPcOE;

    always #5 clock = ~clock;

    jx2_ic_tile_d #(.IC_LINES(16), .PA_BITS(20)) dut (
        .clock(clock), .reset(reset), .regInPc(regInPc), .icFlush(icFlush),
        .regOutPcVal(regOutPcVal), .regOutPcOK(regOutPcOK),
        .memPcData(memPcData), .memPcOK(memPcOK),
        .memPcAddr(memPcAddr), .memPcOE(memPcOE)
    );

    typedef struct packed {
        logic [1:0]  ok;
        logic [31:0] val;
        logic        chk_val;
        logic        chk_oe;
    } exp_t;

    exp_t        stat_q[$];
    string       stat_name_q[$];
    logic [19:0] addr_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_timeouts = 0;
    bit          done = 1'b0;

    // Memory pattern: halfword k of a line is {address bits 16:5, k}.
    function automatic logic [255:0] mk_line(input logic [19:0] a);
        logic [255:0] d;
        for (int k = 0; k < 16; k++) d[16*k +: 16] = {a[16:5], 4'(k)};
        return d;
    endfunction

    task automatic expect_stat(input logic [1:0] ok, input logic [31:0] val,
                               input logic cv, input logic co, input string nm);
        exp_t e;
        e.ok = ok; e.val = val; e.chk_val = cv; e.chk_oe = co;
        stat_q.push_back(e);
        stat_name_q.push_back(nm);
        @(negedge clock); #1;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        @(posedge clock); #1;
        regInPc = pc;
    endtask

    task automatic wait_oe();
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            seen = memPcOE;
        end
        if (!seen) begin
            $display("FAIL wait_req: memPcOE=0 after 30 cycles, required 1");
            n_timeouts++;
        end
    endtask

    task automatic serve(input logic [1:0] resp, input logic flush_at);
        wait_oe();
        @(posedge clock); #1;
        memPcOK   = resp;
        memPcData = mk_line(memPcAddr);
        icFlush   = flush_at;
        @(posedge clock); #1;
        memPcOK = R_READY;
        icFlush = 1'b0;
    endtask

    // Monitor: checks each new request and each queued status expectation.
    initial begin
        logic        oe_prev = 1'b0;
        logic [19:0] ea;
        exp_t        e;
        string       nm;
        bit          bad;
        forever begin
            @(negedge clock);
            if (!reset && memPcOE === 1'b1 && !oe_prev) begin
                n_tests++;
                if (addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_req: got request addr=%h, required no request", memPcAddr);
                end else begin
                    ea = addr_q.pop_front();
                    if (memPcAddr !== ea) begin
                        n_fail++;
                        $display("FAIL req_addr: got %h, required %h", memPcAddr, ea);
                    end
                end
            end
            oe_prev = (memPcOE === 1'b1);
            if (stat_q.size() > 0) begin
                e  = stat_q.pop_front();
                nm = stat_name_q.pop_front();
                n_tests++;
                bad = (regOutPcOK !== e.ok) || (e.chk_val && (regOutPcVal !== e.val)) ||
                      (e.chk_oe && ((memPcOE !== 1'b0) || (memPcAddr !== 20'h00000)));
                if (bad) begin
                    n_fail++;
                    $display("FAIL %s: got ok=%b val=%h oe=%b addr=%h, required ok=%b val=%h (val checked=%0d, oe/addr zero checked=%0d)",
                             nm, regOutPcOK, regOutPcVal, memPcOE, memPcAddr, e.ok, e.val, e.chk_val, e.chk_oe);
                end
            end
            if (done) begin
                n_tests++;
                if (addr_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL req_drain: got %0d requests never issued, required 0", addr_q.size());
                end
                n_tests += n_timeouts;
                n_fail  += n_timeouts;
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        reset = 1'b0; icFlush = 1'b0; regInPc = 32'h40;
        memPcOK = R_READY; memPcData = '0;
        #1 reset = 1'b1;
        @(posedge clock); #1;
        expect_stat(R_HOLD, 32'h0, 1'b0, 1'b1, "reset_state");
        addr_q.push_back(20'h00040);
        @(posedge clock); #1;
        reset = 1'b0;
        expect_stat(R_HOLD, 32'h0, 1'b0, 1'b0, "cold_miss_hold");
        serve(R_OK, 1'b0);
        expect_stat(R_OK, 32'h0021_0020, 1'b1, 1'b0, "cold_hit");

        set_pc(32'h44); expect_stat(R_OK, 32'h0023_0022, 1'b1, 1'b0, "hit_w2");
        set_pc(32'h4E); expect_stat(R_OK, 32'h0028_0027, 1'b1, 1'b0, "hit_w7_even");
        set_pc(32'h5C); expect_stat(R_OK, 32'h002F_002E, 1'b1, 1'b0, "hit_w6_odd");

        addr_q.push_back(20'h00060);
        set_pc(32'h5E); expect_stat(R_HOLD, 32'h0, 1'b0, 1'b0, "straddle_miss");
        serve(R_OK, 1'b0);
        expect_stat(R_OK, 32'h0030_002F, 1'b1, 1'b0, "straddle_hit");

        addr_q.push_back(20'h00080);
        addr_q.push_back(20'h000A0);
        set_pc(32'h9E); expect_stat(R_HOLD, 32'h0, 1'b0, 1'b0, "dual_miss");
        serve(R_OK, 1'b0);
        expect_stat(R_HOLD, 32'h0, 1'b0, 1'b0, "dual_between");
        serve(R_OK, 1'b0);
        expect_stat(R_OK, 32'h0050_004F, 1'b1, 1'b0, "dual_hit");

        addr_q.push_back(20'h00240);
        set_pc(32'h240); expect_stat(R_HOLD, 32'h0, 1'b0, 1'b0, "conflict_miss");
        serve(R_OK, 1'b0);
        expect_stat(R_OK, 32'h0121_0120, 1'b1, 1'b0, "conflict_hit");
        addr_q.push_back(20'h00040);
        set_pc(32'h40); expect_stat(R_HOLD, 32'h0, 1'b0, 1'b0, "conflict_evict");
        serve(R_OK, 1'b0);
        expect_stat(R_OK, 32'h0021_0020, 1'b1, 1'b0, "refill_hit");

        addr_q.push_back(20'h00100);
        set_pc(32'h100); expect_stat(R_HOLD, 32'h0, 1'b0, 1'b0, "fault_miss");
        serve(R_FAULT, 1'b0);
        expect_stat(R_FAULT, 32'h0, 1'b0, 1'b0, "fault_status");
        set_pc(32'h11C); expect_stat(R_FAULT, 32'h0, 1'b0, 1'b0, "fault_range");
        set_pc(32'h40);  expect_stat(R_OK, 32'h0021_0020, 1'b1, 1'b0, "fault_other_hit");
        addr_q.push_back(20'h00100);
        set_pc(32'h100); expect_stat(R_HOLD, 32'h0, 1'b0, 1'b0, "fault_recover");
        serve(R_OK, 1'b0);
        expect_stat(R_OK, 32'h0081_0080, 1'b1, 1'b0, "fault_refetch");

        @(posedge clock); #1;
        regInPc = 32'h40; icFlush = 1'b1;
        expect_stat(R_OK, 32'h0021_0020, 1'b1, 1'b0, "pre_flush_hit");
        addr_q.push_back(20'h00040);
        @(posedge clock); #1;
        icFlush = 1'b0;
        expect_stat(R_HOLD, 32'h0, 1'b0, 1'b0, "flush_clears");
        wait_oe();
        @(posedge clock); #1; icFlush = 1'b1;
        @(posedge clock); #1; icFlush = 1'b0;
        memPcOK = R_OK; memPcData = mk_line(memPcAddr);
        @(posedge clock); #1; memPcOK = R_READY;
        expect_stat(R_HOLD, 32'h0, 1'b0, 1'b0, "flush_in_req_discard");
        addr_q.push_back(20'h00040);
        addr_q.push_back(20'h00040);
        serve(R_OK, 1'b1);
        expect_stat(R_HOLD, 32'h0, 1'b0, 1'b0, "flush_at_fill");
        serve(R_OK, 1'b0);
        expect_stat(R_OK, 32'h0021_0020, 1'b1, 1'b0, "flush_refill");

        addr_q.push_back(20'h00300);
        set_pc(32'h300); expect_stat(R_HOLD, 32'h0, 1'b0, 1'b0, "rst_miss");
        wait_oe();
        @(posedge clock); #1;
        reset = 1'b1; regInPc = 32'h40;
        expect_stat(R_HOLD, 32'h0, 1'b0, 1'b1, "rst_drops_oe");
        addr_q.push_back(20'h00040);
        @(posedge clock); #1;
        reset = 1'b0;
        expect_stat(R_HOLD, 32'h0, 1'b0, 1'b0, "rst_cold_hold");
        serve(R_OK, 1'b0);
        expect_stat(R_OK, 32'h0021_0020, 1'b1, 1'b0, "rst_refill");

        repeat (3) @(posedge clock);
        done = 1'b1;
    end

endmodule
